// File: rtl/pc_sequencer.sv
// Fetch-stage PC register and next-PC select (increment/branch/jump/call/return) with start/halt/done control.
// One-cycle latency from controls to prog_ctr; stall freezes all state.
module pc_sequencer #(
  parameter int D         = 12,
  parameter int OFF_W     = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         stall,
  input  logic         branch_en,
  input  logic         jump_abs,
  input  logic         call_en,
  input  logic         ret_en,
  input  logic         halt,
  input  logic [D-1:0] target,
  output logic [D-1:0] prog_ctr,
  output logic         fetch_valid,
  output logic         done,
  output logic         ras_err
);

  localparam int IDX_W = $clog2(RAS_DEPTH);
  localparam int SP_W  = IDX_W + 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(RAS_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

  state_t          state;
  logic [SP_W-1:0] sp;
  logic [D-1:0]    ras [RAS_DEPTH];

  logic            active;
  logic            ras_empty;
  logic            ras_full;
  logic            do_push;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] top_idx;
  logic [D-1:0]    pc_inc;
  logic [D-1:0]    pc_rel;

  assign active    = (state == S_RUN) && !stall;
  assign ras_empty = (sp == '0);
  assign ras_full  = (sp == SP_FULL);
  assign push_idx  = sp[IDX_W-1:0];
  assign top_idx   = sp[IDX_W-1:0] - 1'b1;
  assign pc_inc    = prog_ctr + 1'b1;
  assign pc_rel    = prog_ctr + {{(D-OFF_W){target[OFF_W-1]}}, target[OFF_W-1:0]};
  // A simultaneous ret wins over call, so no push happens in that case.
  assign do_push   = active && !halt && !ret_en && call_en && !ras_full;

  always_ff @(posedge clk) begin
    if (do_push) ras[push_idx] <= pc_inc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      prog_ctr    <= '0;
      fetch_valid <= 1'b0;
      done        <= 1'b0;
      ras_err     <= 1'b0;
      sp          <= '0;
    end else if (!stall) begin
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            state       <= S_RUN;
            prog_ctr    <= '0;
            fetch_valid <= 1'b1;
            done        <= 1'b0;
            ras_err     <= 1'b0;
            sp          <= '0;
          end
        end
        S_RUN: begin
          if (halt) begin
            state       <= S_HALTED;
            fetch_valid <= 1'b0;
            done        <= 1'b1;
          end else if (ret_en) begin
            if (ras_empty) begin
              ras_err  <= 1'b1;
              prog_ctr <= pc_inc;
            end else begin
              prog_ctr <= ras[top_idx];
              sp       <= sp - 1'b1;
            end
          end else if (call_en) begin
            if (ras_full) ras_err <= 1'b1;
            else          sp      <= sp + 1'b1;
            prog_ctr <= target;
          end else if (jump_abs) begin
            prog_ctr <= target;
          end else if (branch_en) begin
            prog_ctr <= pc_rel;
          end else begin
            prog_ctr <= pc_inc;
          end
        end
        default: begin
          state       <= S_IDLE;
          prog_ctr    <= '0;
          fetch_valid <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule
